// File: rtl/ps2_key_fifo.sv
// PS/2 set-2 keyboard front end: frame receiver, make/break decoder, ASCII key FIFO.
// Latency: key pushed 1 clk after the stop-bit edge; key_valid/key_ascii follow 1 clk later.
// Backpressure: valid/ready pop; keys arriving while the FIFO is full are dropped with an overflow pulse.
// Ports: clk/rst_n (CLOCK_50, async active-low reset); ps2_clk/ps2_dat (raw PS/2 pins);
//        key_ready/key_valid/key_ascii (consumer handshake); frame_err, overflow (1-clk pulses);
//        held (a mapped non-extended key is down).
module ps2_key_fifo #(
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 50000,
  parameter int REPEAT_EN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_ascii,
  output logic       frame_err,
  output logic       overflow,
  output logic       held
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  // ---------------- synchronisers ----------------
  // Bit 0 is the first stage, bit 2 the oldest. Reset high to match an idle bus.
  logic [2:0] clk_sync_q, dat_sync_q;
  logic       ps2_fall, ps2_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[1:0], ps2_dat};
    end
  end

  // High-to-low transition between the two later stages.
  assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign ps2_bit  = dat_sync_q[1];

  // ---------------- frame receiver ----------------
  rx_state_t       rx_state_q;
  logic [3:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [TW-1:0]   tout_q;
  logic            rx_vld_q;
  logic [7:0]      rx_byte_q;
  logic            frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tout_q      <= '0;
      rx_vld_q    <= 1'b0;
      rx_byte_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_state_q == S_IDLE || ps2_fall) tout_q <= '0;
      else                                  tout_q <= tout_q + TW'(1);
      if (ps2_fall) begin
        case (rx_state_q)
          S_IDLE: begin
            // A high start bit is line noise; stay put without flagging it.
            if (!ps2_bit) begin
              rx_state_q <= S_DATA;
              bit_cnt_q  <= 4'd0;
            end
          end
          S_DATA: begin
            shift_q   <= {ps2_bit, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) rx_state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q      <= ps2_bit;
            rx_state_q <= S_STOP;
          end
          default: begin
            if ((^{shift_q, par_q}) && ps2_bit) begin
              rx_vld_q  <= 1'b1;
              rx_byte_q <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
            rx_state_q <= S_IDLE;
          end
        endcase
      end else if (rx_state_q != S_IDLE && tout_q == TOUT_LAST) begin
        // Abandon a stalled partial frame without reporting it.
        rx_state_q <= S_IDLE;
      end
    end
  end

  // ---------------- scan code decoder ----------------
  logic [7:0] map_ascii;
  logic       map_vld, is_prefix, key_push;
  logic       brk_q, ext_q, held_q;
  logic [7:0] hcode_q;

  always_comb begin
    map_ascii = 8'h00;
    case (rx_byte_q)
      8'h1C: map_ascii = 8'h41;  8'h32: map_ascii = 8'h42;  8'h21: map_ascii = 8'h43;
      8'h23: map_ascii = 8'h44;  8'h24: map_ascii = 8'h45;  8'h2B: map_ascii = 8'h46;
      8'h34: map_ascii = 8'h47;  8'h33: map_ascii = 8'h48;  8'h43: map_ascii = 8'h49;
      8'h3B: map_ascii = 8'h4A;  8'h42: map_ascii = 8'h4B;  8'h4B: map_ascii = 8'h4C;
      8'h3A: map_ascii = 8'h4D;  8'h31: map_ascii = 8'h4E;  8'h44: map_ascii = 8'h4F;
      8'h4D: map_ascii = 8'h50;  8'h15: map_ascii = 8'h51;  8'h2D: map_ascii = 8'h52;
      8'h1B: map_ascii = 8'h53;  8'h2C: map_ascii = 8'h54;  8'h3C: map_ascii = 8'h55;
      8'h2A: map_ascii = 8'h56;  8'h1D: map_ascii = 8'h57;  8'h22: map_ascii = 8'h58;
      8'h35: map_ascii = 8'h59;  8'h1A: map_ascii = 8'h5A;
      8'h45: map_ascii = 8'h30;  8'h16: map_ascii = 8'h31;  8'h1E: map_ascii = 8'h32;
      8'h26: map_ascii = 8'h33;  8'h25: map_ascii = 8'h34;  8'h2E: map_ascii = 8'h35;
      8'h36: map_ascii = 8'h36;  8'h3D: map_ascii = 8'h37;  8'h3E: map_ascii = 8'h38;
      8'h46: map_ascii = 8'h39;
      8'h29: map_ascii = 8'h20;  8'h5A: map_ascii = 8'h0D;
      default: map_ascii = 8'h00;
    endcase
  end

  // Every mapped character is non-zero, so zero doubles as "unmapped".
  assign map_vld   = |map_ascii;
  assign is_prefix = (rx_byte_q == 8'hF0) || (rx_byte_q == 8'hE0);
  assign key_push  = rx_vld_q && !is_prefix && !ext_q && !brk_q && map_vld &&
                     ((rx_byte_q != hcode_q) || (REPEAT_EN != 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      held_q  <= 1'b0;
      hcode_q <= 8'h00;
    end else if (rx_vld_q) begin
      if (rx_byte_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else if (rx_byte_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
        if (!ext_q) begin
          if (brk_q) begin
            if (rx_byte_q == hcode_q) begin
              hcode_q <= 8'h00;
              held_q  <= 1'b0;
            end
          end else if (map_vld && rx_byte_q != hcode_q) begin
            hcode_q <= rx_byte_q;
            held_q  <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- key FIFO ----------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          key_valid_q, ovf_q;
  logic [7:0]    key_ascii_q, head_d;
  logic          pop, full, push_eff;

  assign pop      = key_valid_q && key_ready;
  assign full     = (cnt_q == CNT_FULL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_eff = key_push && (!full || pop);
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_eff, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    // Registered head: bypass the key being written when it becomes the new head.
    if (cnt_d == '0)                           head_d = 8'h00;
    else if (push_eff && rd_ptr_d == wr_ptr_q) head_d = map_ascii;
    else                                       head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= map_ascii;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_ascii_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      key_valid_q <= (cnt_d != '0);
      key_ascii_q <= head_d;
      ovf_q       <= key_push && full && !pop;
    end
  end

  assign key_valid = key_valid_q;
  assign key_ascii = key_ascii_q;
  assign frame_err = frame_err_q;
  assign overflow  = ovf_q;
  assign held      = held_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for ps2_key_fifo: two instances (typematic repeat off / on) share all inputs.
// Directed scenarios followed by random scan-code traffic, checked against a queue model.
// Key pops are driven by the bench between frames; one directed pop coincides with a push.
module tb_ps2_key_fifo;
  localparam int DEPTH = 8;
  localparam int TOUT  = 200;
  localparam int HALF  = 12;

  localparam logic [7:0] LET_CODE [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_CODE [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] POOL [7] = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h29, 8'h5A, 8'h16};

  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1, key_ready = 1'b0;
  logic kv0, kv1, fe0, fe1, ov0, ov1, hd0, hd1;
  logic [7:0] ka0, ka1;

  always #5 clk = ~clk;

  ps2_key_fifo #(.DEPTH(DEPTH), .TIMEOUT(TOUT), .REPEAT_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .key_ready(key_ready),
    .key_valid(kv0), .key_ascii(ka0), .frame_err(fe0), .overflow(ov0), .held(hd0));
  ps2_key_fifo #(.DEPTH(DEPTH), .TIMEOUT(TOUT), .REPEAT_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .key_ready(key_ready),
    .key_valid(kv1), .key_ascii(ka1), .frame_err(fe1), .overflow(ov1), .held(hd1));

  int n_vec = 0, n_bad = 0;
  int fe0_n = 0, fe1_n = 0, ov0_n = 0, ov1_n = 0;

  // Pulse counters: a pulse stuck high for extra cycles shows up as extra counts.
  always @(negedge clk) begin
    if (fe0) fe0_n++;
    if (fe1) fe1_n++;
    if (ov0) ov0_n++;
    if (ov1) ov1_n++;
  end

  // Reference model: expected FIFO contents per instance and decoder state.
  logic [7:0] q0[$], q1[$];
  logic       m_brk = 1'b0, m_ext = 1'b0, m_held = 1'b0;
  logic [7:0] m_hcode = 8'h00;
  int         exp_fe = 0, exp_ov0 = 0, exp_ov1 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_map(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (c == LET_CODE[i]) return 8'(8'h41 + i);
    for (int i = 0; i < 10; i++) if (c == DIG_CODE[i]) return 8'(8'h30 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_byte(input logic [7:0] c);
    logic [7:0] a;
    logic p0, p1;
    a = ref_map(c);
    p0 = 1'b0;
    p1 = 1'b0;
    if (c == 8'hF0) m_brk = 1'b1;
    else if (c == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext) begin
        if (m_brk) begin
          if (c == m_hcode) begin m_hcode = 8'h00; m_held = 1'b0; end
        end else if (a != 8'h00) begin
          p1 = 1'b1;
          p0 = (c != m_hcode);
          m_hcode = c;
          m_held = 1'b1;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    if (p0) begin
      if (q0.size() < DEPTH) q0.push_back(a); else exp_ov0++;
    end
    if (p1) begin
      if (q1.size() < DEPTH) q1.push_back(a); else exp_ov1++;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic check_heads();
    check("valid0", kv0, q0.size() != 0);
    check("ascii0", ka0, (q0.size() != 0) ? q0[0] : 8'h00);
    check("valid1", kv1, q1.size() != 0);
    check("ascii1", ka1, (q1.size() != 0) ? q1[0] : 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic bad_par, input logic bad_stop,
                            input logic pop_at_push);
    logic par;
    int   sz0;
    par = ~(^c) ^ bad_par;
    sz0 = q0.size();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit(par);
    ps2_dat = ~bad_stop;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(3);
    // One cycle before the push: the new key must not be visible yet.
    if (sz0 == 0) check("lat_early", kv0, 1'b0);
    if (pop_at_push) begin
      check_heads();
      key_ready = 1'b1;
    end
    wait_clk(1);
    key_ready = 1'b0;
    if (pop_at_push) begin
      if (q0.size() != 0) void'(q0.pop_front());
      if (q1.size() != 0) void'(q1.pop_front());
    end
    if (!bad_par && !bad_stop) model_byte(c);
    else exp_fe++;
    if (sz0 == 0 && q0.size() != 0) begin
      check("lat_valid", kv0, 1'b1);
      check("lat_ascii", ka0, q0[0]);
    end
    wait_clk(HALF);
    ps2_clk = 1'b1;
    wait_clk(HALF);
    check_heads();
    check("held0", hd0, m_held);
    check("held1", hd1, m_held);
    check("frame_err0", fe0_n, exp_fe);
    check("frame_err1", fe1_n, exp_fe);
    check("overflow0", ov0_n, exp_ov0);
    check("overflow1", ov1_n, exp_ov1);
  endtask

  task automatic good(input logic [7:0] c);
    send_frame(c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_some(input int n);
    for (int i = 0; i < n; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      check_heads();
      key_ready = 1'b1;
      wait_clk(1);
      key_ready = 1'b0;
      if (q0.size() != 0) void'(q0.pop_front());
      if (q1.size() != 0) void'(q1.pop_front());
    end
    check_heads();
  endtask

  task automatic drain();
    pop_some(2 * DEPTH + 4);
  endtask

  initial begin
    // Reset state
    wait_clk(3);
    check("rst_valid0", kv0, 1'b0);  check("rst_ascii0", ka0, 8'h00);
    check("rst_ferr0", fe0, 1'b0);   check("rst_ovf0", ov0, 1'b0);
    check("rst_held0", hd0, 1'b0);   check("rst_valid1", kv1, 1'b0);
    check("rst_held1", hd1, 1'b0);   check("rst_ascii1", ka1, 8'h00);
    rst_n = 1'b1;
    wait_clk(2);
    // Reset in the middle of a frame, then a clean make 1C
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    wait_clk(4);
    check("midrst_valid", kv0, 1'b0);
    rst_n = 1'b1;
    wait_clk(20);
    check("midrst_noerr", fe0_n, 0);
    check("midrst_noout", kv0, 1'b0);
    good(8'h1C);

    // Press / release / press
    good(8'hF0);
    good(8'h1C);
    good(8'h1C);
    drain();

    // Typematic repeats
    good(8'h32); good(8'h32); good(8'h32); good(8'hF0); good(8'h32);
    drain();

    // Frame errors and a timed-out partial frame
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_clk(TOUT + 50);
    good(8'h45);
    drain();

    // Extended and unmapped codes
    good(8'hE0); good(8'h5A); good(8'h76);
    good(8'h5A);
    drain();

    // FIFO boundary: fill, overflow, pop coinciding with a push, drain with wrap
    for (int i = 0; i < 9; i++) good(LET_CODE[i]);
    send_frame(LET_CODE[9], 1'b0, 1'b0, 1'b1);
    drain();

    // Random traffic
    for (int n = 0; n < 50; n++) begin
      logic [7:0] c;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) c = 8'hF0;
      else if (r == 1) c = 8'hE0;
      else if (r == 2) c = 8'h76;
      else c = POOL[$urandom_range(0, 6)];
      send_frame(c, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 4), 1'b0);
      pop_some($urandom_range(0, 3));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
